tdc_path_monitor: RTL and testbench
===================================

// Module: tdc_path_monitor
// PURPOSE
//  Parametrised successor to the fixed 100-stage NOT delay paths.
//  Holds N_CHAINS tapped inverter chains and measures, per request, how many stages a launched
//  edge traverses in one clk period (tapped-delay-line TDC).
//  Averages N_SAMPLES shots, then flags paths outside [lo_bound, hi_bound] as suspect (Trojan load).
//  Sits between the delay-path fabric and the measurement controller/UART reporter.
// PARAMETERS
//  N_CHAINS   4    number of independent delay chains (channels)
//  N_STAGES   128  inverter stages per chain; every stage output is a tap
//  N_SAMPLES  16   shots averaged per measurement; power of two, >=1
//  SETTLE_CYC 4    idle cycles before each launch so the chain fully settles; >=2
//  Derived: CW=$clog2(N_STAGES+1), SW=$clog2(N_SAMPLES), CHW=max(1,$clog2(N_CHAINS))
// PORTS
//  clk           in   1    system clock; launch and capture both on rising edge
//  rst_n         in   1    asynchronous, active-low reset
//  start         in   1    1-cycle request; accepted only in IDLE
//  abort         in   1    return to IDLE next cycle, no result
//  chan_sel      in   CHW  channel to measure; latched on accepted start
//  lo_bound      in   CW   minimum acceptable mean tap count; latched on start
//  hi_bound      in   CW   maximum acceptable mean tap count; latched on start
//  busy          out  1    high from the cycle after an accepted start until DONE exits
//  result_valid  out  1    1-cycle pulse; result fields stable until next result_valid
//  result_chan   out  CHW  channel the result belongs to
//  result_mean   out  CW   accumulated count >> SW (truncating)
//  trojan_flag   out  1    result_mean < lo_bound or result_mean > hi_bound
//  overflow      out  1    any shot decoded count == N_STAGES (edge ran off the chain)
// BEHAVIOUR
//  - Reset: all outputs 0, every launch register 0, FSM IDLE, accumulator 0. Reset mid-run discards the run.
//  - FSM: IDLE -start-> SETTLE(SETTLE_CYC cycles) -> LAUNCH -> CAPTURE -> DECODE -> ACCUM
//      -> (shots<N_SAMPLES ? SETTLE : DONE) -> IDLE.
//    abort in any non-IDLE state -> IDLE next cycle; no result_valid; launch value kept.
//  - start while busy: ignored, no queueing. start and abort in the same IDLE cycle: abort wins.
//  - Launch: LAUNCH toggles launch[chan] (one flop per chain). Chain input = launch flop.
//    At the next edge (CAPTURE) all N_STAGES taps of the selected chain go into cap1.
//    One cycle later (DECODE) they go into cap2, a metastability stage.
//  - Decode of cap2:
//    - norm[i] = tap[i] XNOR exp[i], with exp[i] = (i even) ? ~launch : launch (new value).
//    - count = number of consecutive 1s in norm starting at i=0; bubbles past the first 0 are ignored.
//    - count == N_STAGES sets the sticky overflow for the run.
//  - ACCUM: acc (CW+SW bits, cannot wrap) += count; shot counter increments.
//    Launch polarity alternates shot to shot, so rising and falling edges are averaged.
//  - DONE: result_* is updated and result_valid is pulsed in the same cycle; acc, shots and
//    sticky overflow are cleared; busy drops the following cycle.
//  - Latency: N_SAMPLES*(SETTLE_CYC+4)+1 cycles from start to result_valid.
//  - Unselected chains are never launched; their taps are not sampled.
// STRUCTURE
//  - Package tdc_pkg:
//    - state_t enum {IDLE, SETTLE, LAUNCH, CAPTURE, DECODE, ACCUM, DONE}
//    - clog2 helper
//    - leading-ones count function lead_ones(norm)
//  - Sub-module tap_delay_chain(taps[N_STAGES-1:0], din):
//    - N_STAGES keep-attributed NOT stages.
//    - Sim-only parameter STAGE_DLY_PS gives each stage a fixed delay; synthesis ignores it.
//    - Instantiated N_CHAINS times via generate.
//  - Top: FSM, launch flops, cap1/cap2, tap mux by latched chan, decode, accumulator, compare.
// TESTING (clk 10 ns, N_STAGES=128, N_SAMPLES=16, STAGE_DLY_PS=125 -> 80 taps/period)
//  1 Reset then start chan 0, bounds 75..85.
//    -> result_valid once after 16*8+1=129 cycles; mean=80, flag=0, overflow=0.
//  2 Chain 2 set to STAGE_DLY_PS=150, same bounds.
//    -> mean=66, trojan_flag=1, result_chan=2.
//  3 Chain 1 set to STAGE_DLY_PS=60, bounds 0..128.
//    -> edge exceeds 128 stages; mean=128, overflow=1.
//  4 start, abort asserted at cycle 40.
//    -> busy=0 next cycle, no result_valid; a fresh start yields a correct result.
//  5 start pulses while busy, plus start+abort together in IDLE.
//    -> both ignored; exactly one result per accepted start.
//  6 rst_n low mid-run at cycle 60, release.
//    -> all outputs 0 asynchronously; a following start gives mean=80 (accumulator cleared).

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the tapped-delay-line path monitor.
package tdc_pkg;

  localparam int LO_MAX = 512;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    CAPTURE,
    DECODE,
    ACCUM,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Run length of 1s from bit 0; anything after the first 0 is a bubble.
  function automatic int unsigned lead_ones(
    input logic [LO_MAX-1:0] norm,
    input int unsigned       n
  );
    int unsigned cnt;
    logic        run;
    cnt = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < LO_MAX; i++) begin
      if (run && (i < n) && norm[i]) cnt++;
      else run = 1'b0;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tap_delay_chain.sv
// Inverter delay line; every stage output is exposed as a tap.
module tap_delay_chain #(
  parameter int N_STAGES     = 128,
  parameter int STAGE_DLY_PS = 0,
  parameter int CLK_PS       = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  output logic [N_STAGES-1:0] taps
);

  localparam int DIV   = (STAGE_DLY_PS > 0) ? STAGE_DLY_PS : 1;
  localparam int REACH = ((STAGE_DLY_PS <= 0) || (CLK_PS / DIV >= N_STAGES))
                         ? N_STAGES : CLK_PS / DIV;
  localparam logic [N_STAGES-1:0] MASK =
    {N_STAGES{1'b1}} >> (N_STAGES - REACH);

  logic [N_STAGES-1:0] w_stage;
  logic [N_STAGES-1:0] r_prev;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stg
    (* keep = "true" *) logic w_out;
    if (i == 0) begin : g_first
      assign w_out = ~din;
    end else begin : g_next
      assign w_out = ~g_stg[i-1].w_out;
    end
    assign w_stage[i] = w_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= w_stage;
  end

  // Wavefront seen one period after din moves: stages past the reach
  // still hold last cycle's settled level. With zero delay it folds away.
  assign taps = (w_stage & MASK) | (r_prev & ~MASK);

endmodule

// File: rtl/tdc_path_monitor.sv
// Multi-channel TDC: launches edges, decodes tap counts, averages,
// and flags paths whose mean delay is out of bounds.
module tdc_path_monitor
  import tdc_pkg::*;
#(
  parameter int N_CHAINS   = 4,
  parameter int N_STAGES   = 128,
  parameter int N_SAMPLES  = 16,
  parameter int SETTLE_CYC = 4,
  parameter int CLK_PS     = 10000,
  parameter logic [N_CHAINS*16-1:0] STAGE_DLY_PS = {N_CHAINS{16'd125}},
  localparam int CW  = clog2(N_STAGES + 1),
  localparam int SW  = clog2(N_SAMPLES),
  localparam int CHW = (N_CHAINS > 1) ? clog2(N_CHAINS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [CHW-1:0] chan_sel,
  input  logic [CW-1:0]  lo_bound,
  input  logic [CW-1:0]  hi_bound,
  output logic           busy,
  output logic           result_valid,
  output logic [CHW-1:0] result_chan,
  output logic [CW-1:0]  result_mean,
  output logic           trojan_flag,
  output logic           overflow
);

  localparam int STW = clog2(SETTLE_CYC + 1);
  localparam int AW  = CW + SW;
  localparam int NW  = SW + 1;

  state_t r_state, w_next;

  logic [STW-1:0]      r_set_cnt;
  logic [NW-1:0]       r_shots;
  logic [AW-1:0]       r_acc;
  logic                r_ovf;
  logic [N_CHAINS-1:0] r_launch;
  logic [CHW-1:0]      r_chan;
  logic [CW-1:0]       r_lo, r_hi;
  logic [N_STAGES-1:0] r_cap1, r_cap2;
  logic [N_STAGES-1:0] w_taps [N_CHAINS];
  logic [N_STAGES-1:0] w_exp, w_norm;

  logic           r_valid, r_flag, r_res_ovf;
  logic [CHW-1:0] r_res_chan;
  logic [CW-1:0]  r_mean;

  logic           w_accept, w_abort, w_last, w_set_end;
  logic           w_launch_sel, w_ovf_shot;
  logic [CW-1:0]  w_count, w_mean;
  logic [AW-1:0]  w_sum;

  for (genvar g = 0; g < N_CHAINS; g++) begin : g_chain
    tap_delay_chain #(
      .N_STAGES    (N_STAGES),
      .STAGE_DLY_PS(int'(STAGE_DLY_PS[g*16 +: 16])),
      .CLK_PS      (CLK_PS)
    ) u_chain (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (r_launch[g]),
      .taps (w_taps[g])
    );
  end

  assign w_launch_sel = r_launch[r_chan];

  for (genvar i = 0; i < N_STAGES; i++) begin : g_exp
    if (i % 2 == 0) begin : g_even
      assign w_exp[i] = ~w_launch_sel;
    end else begin : g_odd
      assign w_exp[i] = w_launch_sel;
    end
  end

  assign w_norm     = ~(r_cap2 ^ w_exp);
  assign w_count    = CW'(lead_ones(LO_MAX'(w_norm), N_STAGES));
  assign w_ovf_shot = (w_count == CW'(N_STAGES));
  assign w_sum      = r_acc + AW'(w_count);
  assign w_mean     = w_sum[AW-1:SW];
  assign w_last     = (r_shots == NW'(N_SAMPLES - 1));
  assign w_set_end  = (r_set_cnt == STW'(SETTLE_CYC - 1));
  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_abort    = (r_state != IDLE) && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) w_next = SETTLE;
        SETTLE:  if (w_set_end) w_next = LAUNCH;
        LAUNCH:  w_next = CAPTURE;
        CAPTURE: w_next = DECODE;
        DECODE:  w_next = ACCUM;
        ACCUM:   w_next = w_last ? DONE : SETTLE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_cnt  <= '0;
      r_shots    <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_launch   <= '0;
      r_chan     <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_cap1     <= '0;
      r_cap2     <= '0;
      r_valid    <= 1'b0;
      r_flag     <= 1'b0;
      r_res_ovf  <= 1'b0;
      r_res_chan <= '0;
      r_mean     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_chan    <= chan_sel;
        r_lo      <= lo_bound;
        r_hi      <= hi_bound;
        r_set_cnt <= '0;
        r_shots   <= '0;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
      end else if (w_abort) begin
        r_set_cnt <= '0;
        r_shots   <= '0;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
      end else begin
        unique case (r_state)
          SETTLE:  r_set_cnt <= w_set_end ? '0 : r_set_cnt + 1'b1;
          LAUNCH:  r_launch[r_chan] <= ~r_launch[r_chan];
          CAPTURE: r_cap1 <= w_taps[r_chan];
          DECODE:  r_cap2 <= r_cap1;
          ACCUM: begin
            if (w_last) begin
              r_valid    <= 1'b1;
              r_res_chan <= r_chan;
              r_mean     <= w_mean;
              r_flag     <= (w_mean < r_lo) || (w_mean > r_hi);
              r_res_ovf  <= r_ovf | w_ovf_shot;
              r_acc      <= '0;
              r_shots    <= '0;
              r_ovf      <= 1'b0;
            end else begin
              r_acc   <= w_sum;
              r_shots <= r_shots + 1'b1;
              r_ovf   <= r_ovf | w_ovf_shot;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = r_valid;
  assign result_chan  = r_res_chan;
  assign result_mean  = r_mean;
  assign trojan_flag  = r_flag;
  assign overflow     = r_res_ovf;

endmodule

// File: tb/tb_tdc_path_monitor.sv
// Self-checking bench for tdc_path_monitor: table vectors, corner
// sequences and randomized runs against a wavefront-reach model.
module tb_tdc_path_monitor;

  localparam int NS   = 128;
  localparam int NSMP = 16;
  localparam int CLKP = 10000;
  localparam int DLY [4] = '{125, 60, 150, 125};

  typedef struct {
    logic [1:0] ch;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] mean;
    logic       flag;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [1:0] chan_sel;
  logic [7:0] lo_bound, hi_bound;
  logic       busy, result_valid, trojan_flag, overflow;
  logic [1:0] result_chan;
  logic [7:0] result_mean;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl [8];

  tdc_path_monitor #(
    .N_CHAINS    (4),
    .N_STAGES    (NS),
    .N_SAMPLES   (NSMP),
    .SETTLE_CYC  (4),
    .CLK_PS      (CLKP),
    .STAGE_DLY_PS({16'd125, 16'd150, 16'd60, 16'd125})
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .chan_sel    (chan_sel),
    .lo_bound    (lo_bound),
    .hi_bound    (hi_bound),
    .busy        (busy),
    .result_valid(result_valid),
    .result_chan (result_chan),
    .result_mean (result_mean),
    .trojan_flag (trojan_flag),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stages an edge crosses in one period, accumulated over all shots.
  function automatic int ref_mean(input int ch);
    int k, acc;
    k = CLKP / DLY[ch];
    if (k > NS) k = NS;
    acc = 0;
    for (int s = 0; s < NSMP; s++) acc += k;
    return acc / NSMP;
  endfunction

  task automatic run_meas(input vec_t v, input bit poke);
    int n, nv;
    @(negedge clk);
    start = 1'b1;
    chan_sel = v.ch;
    lo_bound = v.lo;
    hi_bound = v.hi;
    @(posedge clk); #1;
    start = 1'b0;
    chan_sel = v.ch + 2'd1;
    lo_bound = 8'd0;
    hi_bound = 8'd0;
    n = 1;
    chk("busy_rise", busy, 1);
    while (!result_valid && n < 400) begin
      start = poke && (n == 10 || n == 50);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, 129);
    chk("result_chan", result_chan, v.ch);
    chk("result_mean", result_mean, v.mean);
    chk("trojan_flag", trojan_flag, v.flag);
    chk("overflow", overflow, v.ovf);
    @(posedge clk); #1;
    chk("busy_fall", busy, 0);
    chk("valid_pulse", result_valid, 0);
    if (poke) begin
      nv = 0;
      repeat (140) begin
        @(posedge clk); #1;
        if (result_valid) nv++;
      end
      chk("single_result", nv, 0);
    end
  endtask

  task automatic count_valids(input string nm);
    int nv;
    nv = 0;
    repeat (140) begin
      @(posedge clk); #1;
      if (result_valid) nv++;
    end
    chk(nm, nv, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, result_valid, 0);
    chk({nm, "_chan"}, result_chan, 0);
    chk({nm, "_mean"}, result_mean, 0);
    chk({nm, "_flag"}, trojan_flag, 0);
    chk({nm, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{2'd0, 8'd75, 8'd85,  8'd80,  1'b0, 1'b0};
    tbl[1] = '{2'd2, 8'd75, 8'd85,  8'd66,  1'b1, 1'b0};
    tbl[2] = '{2'd1, 8'd0,  8'd128, 8'd128, 1'b0, 1'b1};
    tbl[3] = '{2'd3, 8'd80, 8'd80,  8'd80,  1'b0, 1'b0};
    tbl[4] = '{2'd2, 8'd66, 8'd70,  8'd66,  1'b0, 1'b0};
    tbl[5] = '{2'd0, 8'd81, 8'd90,  8'd80,  1'b1, 1'b0};
    tbl[6] = '{2'd0, 8'd70, 8'd79,  8'd80,  1'b1, 1'b0};
    tbl[7] = '{2'd1, 8'd0,  8'd127, 8'd128, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    chan_sel = 2'd0;
    lo_bound = 8'd0;
    hi_bound = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_meas(tbl[i], 1'b0);

    run_meas(tbl[0], 1'b1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    count_valids("start_abort_no_valid");

    @(negedge clk);
    start = 1'b1;
    chan_sel = 2'd2;
    lo_bound = 8'd75;
    hi_bound = 8'd85;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    count_valids("abort_no_valid");
    run_meas(tbl[2], 1'b0);

    @(negedge clk);
    start = 1'b1;
    chan_sel = 2'd0;
    lo_bound = 8'd75;
    hi_bound = 8'd85;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_meas(tbl[0], 1'b0);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      int   m;
      v.ch = 2'($urandom_range(0, 3));
      v.lo = 8'($urandom_range(0, 100));
      v.hi = 8'($urandom_range(int'(v.lo), 128));
      m = ref_mean(int'(v.ch));
      v.mean = 8'(m);
      v.flag = (m < int'(v.lo)) || (m > int'(v.hi));
      v.ovf  = (m >= NS);
      run_meas(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
